// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Produces pixel/line counters, sync pulses, active-display flag, end-of-active-line
// and new-frame pulses, and a frame counter. Position advances only when en_in is high.
// Optional feature macro: VTG_FRAME_COUNT_EN builds the frame counter; when it is
// undefined fc_out is tied to 0.
module video_timing_gen #(
   parameter int unsigned ACTIVE_H_PIXELS = 1280,
   parameter int unsigned H_FRONT_PORCH   = 110,
   parameter int unsigned H_SYNC_WIDTH    = 40,
   parameter int unsigned H_BACK_PORCH    = 220,
   parameter int unsigned ACTIVE_LINES    = 720,
   parameter int unsigned V_FRONT_PORCH   = 5,
   parameter int unsigned V_SYNC_WIDTH    = 5,
   parameter int unsigned V_BACK_PORCH    = 20,
   parameter logic        HS_POL          = 1'b1,
   parameter logic        VS_POL          = 1'b1,
   parameter int unsigned FRAME_MOD       = 60,
   localparam int unsigned TOTAL_PIXELS   = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
   localparam int unsigned TOTAL_LINES    = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
   localparam int unsigned FCW            = $clog2(FRAME_MOD),
   localparam int unsigned HW             = $clog2(TOTAL_PIXELS),
   localparam int unsigned VW             = $clog2(TOTAL_LINES)
) (
   input  logic           clk_pixel_in,
   input  logic           rst_in,
   input  logic           en_in,
   output logic [HW-1:0]  hcount_out,
   output logic [VW-1:0]  vcount_out,
   output logic           hs_out,
   output logic           vs_out,
   output logic           ad_out,
   output logic           nl_out,
   output logic           nf_out,
   output logic [FCW-1:0] fc_out
);

   localparam int unsigned HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH;
   localparam int unsigned HS_END   = HS_START + H_SYNC_WIDTH;
   localparam int unsigned VS_START = ACTIVE_LINES + V_FRONT_PORCH;
   localparam int unsigned VS_END   = VS_START + V_SYNC_WIDTH;
   localparam logic [HW-1:0] H_LAST = HW'(TOTAL_PIXELS - 1);
   localparam logic [VW-1:0] V_LAST = VW'(TOTAL_LINES - 1);

   typedef enum logic {PRIME, RUN} state_t;

   state_t          state_q;
   logic [HW-1:0]   hcount_q, h_d;
   logic [VW-1:0]   vcount_q, v_d;
   logic            hs_q, hs_d;
   logic            vs_q, vs_d;
   logic            ad_q, ad_d;
   logic            nl_q, nl_d;
   logic            nf_q, nf_d;
   logic [31:0]     h_x, v_x;

   // Next position: PRIME presents (0,0); RUN steps one pixel and wraps line/frame.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      h_d = '0;
      v_d = '0;
      if (state_q == RUN) begin
         if (hcount_q == H_LAST) begin
            h_d = '0;
            v_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
         end else begin
            h_d = hcount_q + 1'b1;
            v_d = vcount_q;
         end
      end
   end

   // Decode the next position so every registered output matches the counters it ships with.
   always_comb begin
      h_x  = 32'(h_d);
      v_x  = 32'(v_d);
      ad_d = (h_x < ACTIVE_H_PIXELS) && (v_x < ACTIVE_LINES);
      hs_d = ((h_x >= HS_START) && (h_x < HS_END)) ? HS_POL : ~HS_POL;
      // vcount only changes on the horizontal wrap, so vsync naturally moves at hcount = 0.
      vs_d = ((v_x >= VS_START) && (v_x < VS_END)) ? VS_POL : ~VS_POL;
      nl_d = (h_x == ACTIVE_H_PIXELS) && (v_x < ACTIVE_LINES);
      nf_d = (h_x == ACTIVE_H_PIXELS) && (v_x == ACTIVE_LINES);
   end

   // State, position and decoded outputs; everything holds while en_in is low.
   always_ff @(posedge clk_pixel_in) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_in) begin
         state_q  <= PRIME;
         hcount_q <= '0;
         vcount_q <= '0;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         ad_q     <= 1'b0;
         nl_q     <= 1'b0;
         nf_q     <= 1'b0;
      end else if (en_in) begin
         state_q  <= RUN;
         hcount_q <= h_d;
         vcount_q <= v_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         ad_q     <= ad_d;
         nl_q     <= nl_d;
         nf_q     <= nf_d;
      end
   end

`ifdef VTG_FRAME_COUNT_EN
   logic [FCW-1:0] fc_q, fc_d;

   // Frame count steps on the enabled edge that brings nf_out high, modulo FRAME_MOD.
   always_comb begin
      fc_d = fc_q;
      if (nf_d) begin
         fc_d = (fc_q == FCW'(FRAME_MOD - 1)) ? '0 : fc_q + 1'b1;
      end
   end

   // Frame counter register, cleared on reset and frozen while stalled.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         fc_q <= '0;
      end else if (en_in) begin
         fc_q <= fc_d;
      end
   end

   assign fc_out = fc_q;
`else
   assign fc_out = '0;
`endif

   assign hcount_out = hcount_q;
   assign vcount_out = vcount_q;
   assign hs_out     = hs_q;
   assign vs_out     = vs_q;
   assign ad_out     = ad_q;
   assign nl_out     = nl_q;
   assign nf_out     = nf_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator that replaces the fixed-format video signal generator in the display path. It produces the pixel/line counters, sync pulses, active-display flag, per-line and per-frame event pulses, and a frame counter for any CEA/VESA-style format. It adds per-signal sync polarity, a configurable frame-counter modulus, a pixel-clock enable for stalls, and an end-of-active-line pulse. It sits directly downstream of the pixel clock and feeds the pixel pipeline and TMDS encoder.

## Interface
- ACTIVE_H_PIXELS, 1280, active pixels per line
- H_FRONT_PORCH, 110, pixels between the end of active video and hsync
- H_SYNC_WIDTH, 40, hsync width in pixels
- H_BACK_PORCH, 220, pixels between hsync and the start of active video
- ACTIVE_LINES, 720, active lines per frame
- V_FRONT_PORCH, 5; V_SYNC_WIDTH, 5; V_BACK_PORCH, 20, vertical blanking in lines
- HS_POL, 1, hsync active level (1 = active-high, 0 = active-low)
- VS_POL, 1, vsync active level (1 = active-high, 0 = active-low)
- FRAME_MOD, 60, frame counter modulus (must be ≥ 2)
- Derived localparams: TOTAL_PIXELS = sum of the H terms; TOTAL_LINES = sum of the V terms; FCW = $clog2(FRAME_MOD)
- clk_pixel_in, input, 1, pixel clock; the only clock
- rst_in, input, 1, reset; synchronous, active-high
- en_in, input, 1, pixel enable; position advances only on cycles where it is high
- hcount_out, output, $clog2(TOTAL_PIXELS), current pixel column
- vcount_out, output, $clog2(TOTAL_LINES), current line
- hs_out, output, 1, horizontal sync at HS_POL
- vs_out, output, 1, vertical sync at VS_POL
- ad_out, output, 1, current position is in the active region
- nl_out, output, 1, end-of-active-line pulse
- nf_out, output, 1, new-frame pulse
- fc_out, output, FCW, frame counter

## Operation
- All outputs are registered and describe the position (hcount_out, vcount_out) presented in the same cycle.
- Reset values: hcount_out = 0, vcount_out = 0, ad_out = 0, hs_out = !HS_POL, vs_out = !VS_POL, nl_out = 0, nf_out = 0, fc_out = 0.
- States:
  - PRIME, entered on reset: counters stay at 0. On the first cycle with en_in = 1, move to RUN and present (0,0) with ad_out = 1.
  - RUN: on each en_in = 1 cycle, advance the position by one pixel.
- Horizontal wrap: hcount = TOTAL_PIXELS-1 goes to 0. Vertical counter increments on the horizontal wrap; vcount = TOTAL_LINES-1 goes to 0 on the wrap.
- Decode (all asserted when the position satisfies the condition):
  - ad_out = 1 iff hcount < ACTIVE_H_PIXELS and vcount < ACTIVE_LINES.
  - hs_out is at its active level iff ACTIVE_H_PIXELS+H_FRONT_PORCH ≤ hcount < that value + H_SYNC_WIDTH.
  - vs_out is at its active level iff ACTIVE_LINES+V_FRONT_PORCH ≤ vcount < that value + V_SYNC_WIDTH. vs_out changes only at hcount = 0.
  - nl_out = 1 iff hcount = ACTIVE_H_PIXELS and vcount < ACTIVE_LINES.
  - nf_out = 1 iff hcount = ACTIVE_H_PIXELS and vcount = ACTIVE_LINES.
- fc_out increments in the same cycle that nf_out first rises. FRAME_MOD-1 wraps to 0.
- en_in = 0: every register holds, including pulses, which therefore stretch. A consumer counts an event only on cycles with en_in = 1. en_in = 0 in PRIME keeps the block in PRIME.
- rst_in has priority over en_in. Asserting rst_in mid-frame returns the block to the reset values and PRIME on the next edge.

## Timing
- Latency from rst_in deassertion: the first edge with en_in = 1 leaves PRIME, and (0,0) appears after that edge. It is held at (0,0) with ad_out = 1 for one cycle, then advances.
- With en_in held high, a frame is exactly TOTAL_PIXELS × TOTAL_LINES cycles and there is no gap at frame wrap.
- hs_out / ad_out transitions occur in the same cycle the counter reaches the boundary value; there is no extra pipeline delay.
- nl_out and nf_out are one enabled cycle wide. nl_out is not asserted on the line where nf_out is asserted.

## Configuration
- VTG_FRAME_COUNT_EN
  - Defined: fc_out is the FRAME_MOD-modulus counter described above.
  - Undefined: no counter register is built, and fc_out is tied to 0. nf_out is unchanged.

## Test plan
All scenarios use ACTIVE_H_PIXELS=8, H_FRONT_PORCH=2, H_SYNC_WIDTH=2, H_BACK_PORCH=2 (TOTAL_PIXELS=14), ACTIVE_LINES=4, V_FRONT_PORCH=1, V_SYNC_WIDTH=1, V_BACK_PORCH=1 (TOTAL_LINES=7), FRAME_MOD=3, and en_in=1 unless stated.
- Reset, then release: all reset values are held during reset. The first cycle after release shows (0,0), ad_out=1. The position reaches (13,6) after 98 cycles and then wraps to (0,0).
- One full line: ad_out is high for hcount 0..7. nl_out is high at hcount 8. hs_out is high at hcount 10..11. With HS_POL=0 the same window is low.
- One full frame: vs_out is high for all of line 5. nf_out pulses once, at (8,4). ad_out stays low for lines 4..6.
- Frame counter over 4 frames with VTG_FRAME_COUNT_EN defined: fc_out goes 1, 2, 0, 1 at each nf_out. With the macro undefined, fc_out is constantly 0.
- Stall: drop en_in for 5 cycles at (8,4). All outputs freeze and nf_out stays high. After en_in returns, the frame still totals 98 enabled cycles.
- Mid-frame reset: assert rst_in at (11,5). The next cycle shows reset values. Release with en_in=0 for 3 cycles; the block stays in PRIME. Raise en_in and (0,0) appears on the next cycle.
